// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the digit-serial add/subtract sequencer.
package addsub_seq_pkg;

  localparam int unsigned SLICE_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Digit index width, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/addsub_seq_ctrl_if.sv
// Request/response bundle between a requester and addsub_seq_ctrl.
interface addsub_seq_ctrl_if #(
  parameter int unsigned DIGITS = 3
);
  import addsub_seq_pkg::*;

  localparam int unsigned W = SLICE_W * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         overflow;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry, overflow, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry, overflow, busy
  );

endinterface

// File: rtl/addsub_slice3.sv
// Combinational 3-bit ripple add slice made of one-bit full adders.
module addsub_slice3
  import addsub_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co,
  output logic               c_msb_in
);

  logic [SLICE_W:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SLICE_W; i++) begin
      s[i]     = x[i] ^ y[i] ^ c[i];
      c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co       = c[SLICE_W];
  assign c_msb_in = c[SLICE_W-1];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Digit-serial two's-complement add/subtract through one shared 3-bit slice, LSB first.
// Define ADDSUB_SEQ_SAT_EN to clamp the result on signed overflow.
module addsub_seq_ctrl
  import addsub_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input logic              clk,
  input logic              rst,
  addsub_seq_ctrl_if.slave bus
);

  localparam int unsigned     W         = SLICE_W * DIGITS;
  localparam int unsigned     IdxW      = idx_width(DIGITS);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(DIGITS - 1);
  localparam logic [W-1:0]    SliceMask = W'({SLICE_W{1'b1}});
`ifdef ADDSUB_SEQ_SAT_EN
  localparam logic [W-1:0]    PosSat    = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0]    NegSat    = {1'b1, {(W - 1){1'b0}}};
`endif

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IdxW-1:0] k_q, k_d;
  logic            cy_q, cy_d;
  logic [W-1:0]    res_q, res_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;

  logic            in_ready;
  logic            accept;
  logic            last;
  logic [31:0]     sh;
  logic [W-1:0]    a_sh, b_sh;
  logic [SLICE_W-1:0] x, y, s;
  logic            co, c_msb_in, ovf_now;

  assign in_ready = (state_q == StIdle) & ~rst;
  assign accept   = in_ready & bus.in_valid;
  assign last     = (k_q == LastIdx);

  // Select the current digit of each latched operand by shifting it down to bit 0.
  assign sh      = 32'(k_q) * SLICE_W;
  assign a_sh    = a_q >> sh;
  assign b_sh    = b_q >> sh;
  assign x       = a_sh[SLICE_W-1:0];
  assign y       = b_sh[SLICE_W-1:0];
  assign ovf_now = c_msb_in ^ co;

  addsub_slice3 u_slice (
    .x        (x),
    .y        (y),
    .ci       (cy_q),
    .s        (s),
    .co       (co),
    .c_msb_in (c_msb_in)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept)        state_d = StRun;
      StRun:   if (last)          state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default:                    state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q != StIdle);
    bus.result    = res_q;
    bus.carry     = carry_q;
    bus.overflow  = ovf_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cy_q    <= cy_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cy_d    = cy_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Subtract is A + ~B + 1: invert B once here, seed the carry with sub.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          cy_d    = bus.sub;
          k_d     = '0;
          res_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        res_d = (res_q & ~(SliceMask << sh)) | (W'(s) << sh);
        cy_d  = co;
        if (last) begin
          carry_d = co;
          ovf_d   = ovf_now;
`ifdef ADDSUB_SEQ_SAT_EN
          // On overflow both effective operands share a sign; a_q's MSB gives it.
          if (ovf_now) begin
            res_d = a_q[W-1] ? NegSat : PosSat;
          end
`endif
        end else begin
          k_d = k_q + IdxW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Randomised self-checking bench for addsub_seq_ctrl with an arithmetic reference model.
module tb_addsub_seq_ctrl;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned W      = 3 * DIGITS;

`ifdef ADDSUB_SEQ_SAT_EN
  localparam logic [W-1:0] ExpAddOvf = 9'h0FF;
  localparam logic [W-1:0] ExpNegOvf = 9'h100;
`else
  localparam logic [W-1:0] ExpAddOvf = 9'h12C;
  localparam logic [W-1:0] ExpNegOvf = 9'h0FF;
`endif

  logic clk;
  logic rst;

  addsub_seq_ctrl_if #(.DIGITS(DIGITS)) bus ();

  addsub_seq_ctrl #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: exact signed arithmetic for overflow, unsigned W+1 bit sum for carry.
  function automatic logic [W+1:0] model_calc(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                               input logic ts);
    longint sa, sb, tru, maxv, minv;
    logic [W:0]   full;
    logic [W-1:0] res;
    logic         ovf;
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb_v));
    tru  = ts ? (sa - sb) : (sa + sb);
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    full = ts ? ({1'b0, ta} + {1'b0, ~tb_v} + (W + 1)'(1)) : ({1'b0, ta} + {1'b0, tb_v});
    ovf  = (tru > maxv) || (tru < minv);
    res  = full[W-1:0];
`ifdef ADDSUB_SEQ_SAT_EN
    if (ovf) res = (tru > 0) ? W'(maxv) : W'(minv);
`endif
    return {res, full[W], ovf};
  endfunction

  // Model state: busy flag, edges since acceptance, expected result.
  bit           m_init  = 0;
  bit           m_busy  = 0;
  bit           m_clear = 0;
  int           m_age   = 0;
  logic [W-1:0] m_res;
  logic         m_c, m_v;

  always @(posedge clk) begin
    if (rst) begin
      m_init  <= 1;
      m_busy  <= 0;
      m_clear <= 1;
      m_age   <= 0;
    end else if (m_init) begin
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy              <= 1;
          m_age               <= 0;
          m_clear             <= 0;
          {m_res, m_c, m_v}   <= model_calc(bus.a, bus.b, bus.sub);
        end
      end else if (m_age >= int'(DIGITS)) begin
        if (bus.out_ready) m_busy <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (m_init) begin
      logic exp_ov;
      exp_ov = m_busy && (m_age >= int'(DIGITS));
      chk("in_ready", 32'(bus.in_ready), 32'(!rst && !m_busy));
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("result", 32'(bus.result), 32'(m_res));
        chk("carry", 32'(bus.carry), 32'(m_c));
        chk("overflow", 32'(bus.overflow), 32'(m_v));
      end else if (!m_busy && m_clear) begin
        chk("reset_result", 32'(bus.result), 32'(0));
        chk("reset_carry", 32'(bus.carry), 32'(0));
        chk("reset_overflow", 32'(bus.overflow), 32'(0));
      end
    end
  end

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                       input int hold, input bit lit, input logic [W-1:0] er,
                       input logic ec, input logic ev);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.sub      = ts;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("accept_timeout", 32'(n), 32'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    // Operands and requests during RUN must be ignored.
    bus.in_valid  = 1'($urandom);
    bus.a         = W'($urandom);
    bus.b         = W'($urandom);
    bus.sub       = 1'($urandom);
    bus.out_ready = 1'($urandom);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      bus.a = W'($urandom);
      bus.out_ready = (bus.out_valid === 1'b1) ? 1'b0 : 1'($urandom);
    end
    chk("latency", 32'(n), 32'(DIGITS));
    if (n >= 20) begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      return;
    end
    if (lit) begin
      chk("lit_result", 32'(bus.result), 32'(er));
      chk("lit_carry", 32'(bus.carry), 32'(ec));
      chk("lit_overflow", 32'(bus.overflow), 32'(ev));
    end
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("in_ready_after_ack", 32'(bus.in_ready), 32'(1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [4];
    corner[0] = '0;
    corner[1] = 9'h100;
    corner[2] = 9'h0FF;
    corner[3] = 9'h1FF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op(9'd100, 9'd50, 1'b0, 5, 1, 9'h096, 1'b0, 1'b0);
    do_op(9'd200, 9'd100, 1'b0, 0, 1, ExpAddOvf, 1'b0, 1'b1);
    do_op(9'd5, 9'd7, 1'b1, 1, 1, 9'h1FE, 1'b0, 1'b0);
    do_op(9'd0, 9'd0, 1'b1, 0, 1, 9'h000, 1'b1, 1'b0);
    do_op(9'h100, 9'd1, 1'b1, 2, 1, ExpNegOvf, 1'b1, 1'b1);

    // Abort an operation after its first slice.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 9'd77;
    bus.b        = 9'd33;
    bus.sub      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_valid", 32'(bus.out_valid), 32'(0));
    chk("abort_result", 32'(bus.result), 32'(0));
    do_op(9'd77, 9'd33, 1'b1, 0, 1, 9'd44, 1'b1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(pick_operand(), pick_operand(), 1'($urandom), $urandom_range(0, 3), 0, '0, 1'b0,
            1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass,
             n_checks);
    $fatal(1);
  end

endmodule
